// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the 64-bit XNOR-feedback PRBS checker:
//   PRBS_WIDTH      word width of the sequence (64)
//   PRBS_TAP_A/B    feedback taps (bits 62 and 61)
//   PRBS_SEED       generator seed value
//   prbs_state_e    checker state (SEARCH, LOCKED)
//   prbs_next()     one-step predictor: shift left, XNOR of the taps into bit 0
// -----------------------------------------------------------------------------
package prbs_pkg;

    localparam int PRBS_WIDTH = 64;
    localparam int PRBS_TAP_A = 62;
    localparam int PRBS_TAP_B = 61;
    localparam logic [PRBS_WIDTH-1:0] PRBS_SEED = 64'h5555_5555_5555_5555;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs_state_e;

    function automatic logic [PRBS_WIDTH-1:0] prbs_next(input logic [PRBS_WIDTH-1:0] cur);
        return {cur[PRBS_WIDTH-2:0], cur[PRBS_TAP_A] ~^ cur[PRBS_TAP_B]};
    endfunction

endpackage

// File: rtl/prbs_popcount.sv
// -----------------------------------------------------------------------------
// prbs_popcount
// Purely combinational population count of a 64-bit word, built as a
// per-byte count followed by a three-level adder tree.
// Ports:
//   data   in   64  word to count
//   count  out  7   number of set bits (0..64)
// -----------------------------------------------------------------------------
module prbs_popcount (
    input  logic [63:0] data,
    output logic [6:0]  count
);

    logic [3:0] byte_cnt_s [8];
    logic [4:0] lvl1_s     [4];
    logic [5:0] lvl2_s     [2];

    // Count the set bits of each byte independently.
    always_comb begin
        for (int b = 0; b < 8; b++) begin
            byte_cnt_s[b] = 4'd0;
            for (int i = 0; i < 8; i++) begin
                byte_cnt_s[b] = byte_cnt_s[b] + {3'b000, data[b*8+i]};
            end
        end
    end

    // Balanced adder tree over the byte counts.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            lvl1_s[j] = {1'b0, byte_cnt_s[2*j]} + {1'b0, byte_cnt_s[2*j+1]};
        end
        for (int k = 0; k < 2; k++) begin
            lvl2_s[k] = {1'b0, lvl1_s[2*k]} + {1'b0, lvl1_s[2*k+1]};
        end
        count = {1'b0, lvl2_s[0]} + {1'b0, lvl2_s[1]};
    end

endmodule

// File: rtl/axis_prbs_checker.sv
// -----------------------------------------------------------------------------
// axis_prbs_checker
// AXI4-Stream sink for the 64-bit XNOR-feedback PRBS. It self-synchronises to
// the incoming sequence (SEARCH), declares lock after LOCK_COUNT consecutive
// predicted beats, and while LOCKED runs a free-running reference so a single
// corrupted word does not disturb later predictions. LOSS_COUNT consecutive
// misses return it to SEARCH. Beat and error counters saturate at all-ones.
//
// Build option: define AXIS_PRBS_CHECKER_BIT_ERR_EN to count bit errors
// (popcount of the difference) instead of one error per mismatching word.
//
// Ports:
//   aclk           in   1                 clock
//   aresetn        in   1                 asynchronous active-low reset
//   cfg_clr        in   1                 sync clear of counters, lock, reference
//   s_axis_tready  out  1                 1 from the first edge after reset
//   s_axis_tdata   in   AXIS_TDATA_WIDTH  received PRBS word
//   s_axis_tvalid  in   1                 beat valid
//   sts_locked     out  1                 1 while LOCKED
//   sts_beat_cnt   out  CNTR_WIDTH        beats accepted while LOCKED
//   sts_err_cnt    out  CNTR_WIDTH        errors counted while LOCKED
// -----------------------------------------------------------------------------
module axis_prbs_checker
    import prbs_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 64,
    parameter int LOCK_COUNT       = 16,
    parameter int LOSS_COUNT       = 8,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_clr,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        sts_locked,
    output logic [CNTR_WIDTH-1:0]       sts_beat_cnt,
    output logic [CNTR_WIDTH-1:0]       sts_err_cnt
);

    // Run counter must hold the larger of the two thresholds; one spare bit
    // keeps the width at least 2 for the replication below.
    localparam int RUN_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1) + 1;

    localparam logic [RUN_W-1:0] RUN_ZERO  = {RUN_W{1'b0}};
    localparam logic [RUN_W-1:0] RUN_ONE   = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_COUNT - 1);

    localparam logic [CNTR_WIDTH-1:0] CNT_ZERO = {CNTR_WIDTH{1'b0}};
    localparam logic [CNTR_WIDTH-1:0] CNT_SAT  = {CNTR_WIDTH{1'b1}};

    prbs_state_e                 state_r;
    logic [AXIS_TDATA_WIDTH-1:0] ref_r;
    logic                        ref_vld_r;
    logic [RUN_W-1:0]            run_r;
    logic [CNTR_WIDTH-1:0]       beat_cnt_r;
    logic [CNTR_WIDTH-1:0]       err_cnt_r;
    logic                        tready_r;
    logic                        locked_r;

    logic [AXIS_TDATA_WIDTH-1:0] pred_s;
    logic                        match_s;
    logic                        beat_s;
    logic [6:0]                  err_inc_s;
    logic [CNTR_WIDTH:0]         beat_sum_s;
    logic [CNTR_WIDTH:0]         err_sum_s;
    logic [CNTR_WIDTH-1:0]       beat_cnt_nxt_s;
    logic [CNTR_WIDTH-1:0]       err_cnt_nxt_s;

    assign pred_s  = prbs_next(ref_r);
    assign match_s = (s_axis_tdata == pred_s) && ref_vld_r;
    assign beat_s  = s_axis_tvalid && tready_r;

`ifdef AXIS_PRBS_CHECKER_BIT_ERR_EN
    logic [AXIS_TDATA_WIDTH-1:0] diff_s;
    assign diff_s = s_axis_tdata ^ pred_s;

    prbs_popcount u_popcount (
        .data  (diff_s),
        .count (err_inc_s)
    );
`else
    assign err_inc_s = 7'd1;
`endif

    // Saturating increments: the extra carry bit flags overflow.
    always_comb begin
        beat_sum_s = {1'b0, beat_cnt_r} + {CNT_ZERO, 1'b1};
        err_sum_s  = {1'b0, err_cnt_r} + {{(CNTR_WIDTH-6){1'b0}}, err_inc_s};
        if (beat_sum_s[CNTR_WIDTH]) begin
            beat_cnt_nxt_s = CNT_SAT;
        end else begin
            beat_cnt_nxt_s = beat_sum_s[CNTR_WIDTH-1:0];
        end
        if (err_sum_s[CNTR_WIDTH]) begin
            err_cnt_nxt_s = CNT_SAT;
        end else begin
            err_cnt_nxt_s = err_sum_s[CNTR_WIDTH-1:0];
        end
    end

    // Lock FSM, reference register, run counter and status counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r    <= SEARCH;
            ref_r      <= {AXIS_TDATA_WIDTH{1'b0}};
            ref_vld_r  <= 1'b0;
            run_r      <= RUN_ZERO;
            beat_cnt_r <= CNT_ZERO;
            err_cnt_r  <= CNT_ZERO;
            tready_r   <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            tready_r <= 1'b1;
            if (cfg_clr) begin
                // Clear wins over a simultaneous beat; that beat is dropped.
                state_r    <= SEARCH;
                ref_r      <= {AXIS_TDATA_WIDTH{1'b0}};
                ref_vld_r  <= 1'b0;
                run_r      <= RUN_ZERO;
                beat_cnt_r <= CNT_ZERO;
                err_cnt_r  <= CNT_ZERO;
                locked_r   <= 1'b0;
            end else if (beat_s) begin
                case (state_r)
                    SEARCH: begin
                        // Re-seed from the received word every beat.
                        ref_r     <= s_axis_tdata;
                        ref_vld_r <= 1'b1;
                        if (match_s) begin
                            if (run_r == LOCK_LAST) begin
                                state_r  <= LOCKED;
                                locked_r <= 1'b1;
                                run_r    <= RUN_ZERO;
                            end else begin
                                run_r <= run_r + RUN_ONE;
                            end
                        end else begin
                            run_r <= RUN_ZERO;
                        end
                    end
                    LOCKED: begin
                        beat_cnt_r <= beat_cnt_nxt_s;
                        if (match_s) begin
                            ref_r <= pred_s;
                            run_r <= RUN_ZERO;
                        end else begin
                            err_cnt_r <= err_cnt_nxt_s;
                            if (run_r == LOSS_LAST) begin
                                state_r  <= SEARCH;
                                locked_r <= 1'b0;
                                ref_r    <= s_axis_tdata;
                                run_r    <= RUN_ZERO;
                            end else begin
                                // Free-running copy: ignore the bad word.
                                ref_r <= pred_s;
                                run_r <= run_r + RUN_ONE;
                            end
                        end
                    end
                    default: begin
                        state_r  <= SEARCH;
                        locked_r <= 1'b0;
                        run_r    <= RUN_ZERO;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign s_axis_tready = tready_r;
    assign sts_locked    = locked_r;
    assign sts_beat_cnt  = beat_cnt_r;
    assign sts_err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_axis_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_axis_prbs_checker
// Directed bench for axis_prbs_checker. A behavioural model computes the
// expected status after every driven cycle and pushes it to a scoreboard
// queue; the entry is popped and compared one edge later. Counters are
// instantiated 8 bits wide so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_axis_prbs_checker;

    localparam int LOCK_N = 16;
    localparam int LOSS_N = 8;
    localparam int CW     = 8;
    localparam int CMAX   = (1 << CW) - 1;

    logic          aclk;
    logic          aresetn;
    logic          cfg_clr;
    logic          s_axis_tready;
    logic [63:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          sts_locked;
    logic [CW-1:0] sts_beat_cnt;
    logic [CW-1:0] sts_err_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit lk;
        int bc;
        int ec;
    } exp_t;

    exp_t sb[$];

    // Model state
    bit          m_locked;
    bit          m_vld;
    logic [63:0] m_ref;
    int          m_run;
    int          m_beat;
    int          m_err;

    logic [63:0] tx;

    axis_prbs_checker #(
        .AXIS_TDATA_WIDTH (64),
        .LOCK_COUNT       (LOCK_N),
        .LOSS_COUNT       (LOSS_N),
        .CNTR_WIDTH       (CW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_clr       (cfg_clr),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .sts_locked    (sts_locked),
        .sts_beat_cnt  (sts_beat_cnt),
        .sts_err_cnt   (sts_err_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [63:0] nxt(input logic [63:0] r);
        logic fb;
        fb = ~(r[62] ^ r[61]);
        return (r << 1) | {63'd0, fb};
    endfunction

    function automatic int err_weight(input logic [63:0] d);
`ifdef AXIS_PRBS_CHECKER_BIT_ERR_EN
        return $countones(d);
`else
        return (d != 64'd0) ? 1 : 0;
`endif
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_locked = 1'b0;
        m_vld    = 1'b0;
        m_ref    = 64'd0;
        m_run    = 0;
        m_beat   = 0;
        m_err    = 0;
    endtask

    task automatic model_beat(input logic [63:0] d);
        logic [63:0] p;
        bit          hit;
        p   = nxt(m_ref);
        hit = m_vld && (d == p);
        if (!m_locked) begin
            m_ref = d;
            m_vld = 1'b1;
            if (hit) begin
                m_run++;
                if (m_run == LOCK_N) begin
                    m_locked = 1'b1;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            m_beat = sat(m_beat + 1);
            if (hit) begin
                m_ref = p;
                m_run = 0;
            end else begin
                m_err = sat(m_err + err_weight(d ^ p));
                m_run++;
                if (m_run == LOSS_N) begin
                    m_locked = 1'b0;
                    m_ref    = d;
                    m_run    = 0;
                end else begin
                    m_ref = p;
                end
            end
        end
    endtask

    // One clock of stimulus: drive, predict, then compare after the edge.
    task automatic step(input bit v, input logic [63:0] d, input bit clr);
        exp_t e;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        cfg_clr       = clr;
        if (clr) model_clear();
        else if (v) model_beat(d);
        sb.push_back('{m_locked, m_beat, m_err});
        @(posedge aclk);
        #1;
        e = sb.pop_front();
        chk("sts_locked",   {63'd0, sts_locked},    {63'd0, e.lk});
        chk("sts_beat_cnt", {56'd0, sts_beat_cnt}, 64'(e.bc));
        chk("sts_err_cnt",  {56'd0, sts_err_cnt},  64'(e.ec));
        s_axis_tvalid = 1'b0;
        cfg_clr       = 1'b0;
    endtask

    task automatic send_good(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, tx, 1'b0);
            tx = nxt(tx);
        end
    endtask

    task automatic send_bad(input logic [63:0] mask);
        step(1'b1, tx ^ mask, 1'b0);
        tx = nxt(tx);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        model_clear();
        #1;
        chk("rst_locked", {63'd0, sts_locked},    64'd0);
        chk("rst_beat",   {56'd0, sts_beat_cnt},  64'd0);
        chk("rst_err",    {56'd0, sts_err_cnt},   64'd0);
        chk("rst_tready", {63'd0, s_axis_tready}, 64'd0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("tready_up", {63'd0, s_axis_tready}, 64'd1);
    endtask

    initial begin
        aresetn       = 1'b0;
        cfg_clr       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 64'd0;
        #2;
        do_reset();

        // 1: seeded stream; 16th consecutive match is beat 17
        tx = 64'h5555_5555_5555_5555;
        chk("second_word", nxt(tx), 64'hAAAA_AAAA_AAAA_AAAA);
        send_good(16);
        chk("t1_not_yet", {63'd0, sts_locked}, 64'd0);
        send_good(1);
        chk("t1_locked", {63'd0, sts_locked}, 64'd1);
        send_good(3);
        chk("t1_beats", {56'd0, sts_beat_cnt}, 64'd3);
        chk("t1_errs",  {56'd0, sts_err_cnt},  64'd0);

        // 2: single-bit error
        send_bad(64'h1);
        chk("t2_err", {56'd0, sts_err_cnt}, 64'd1);
        send_good(2);
        chk("t2_held", {63'd0, sts_locked}, 64'd1);

        // 3: eight-bit error
        send_bad(64'hFF);
`ifdef AXIS_PRBS_CHECKER_BIT_ERR_EN
        chk("t3_err", {56'd0, sts_err_cnt}, 64'd9);
`else
        chk("t3_err", {56'd0, sts_err_cnt}, 64'd2);
`endif
        send_good(2);

        // 4: eight zero words drop lock, then relock
        for (int i = 0; i < LOSS_N - 1; i++) begin
            step(1'b1, 64'd0, 1'b0);
            tx = nxt(tx);
        end
        chk("t4_still", {63'd0, sts_locked}, 64'd1);
        step(1'b1, 64'd0, 1'b0);
        tx = nxt(tx);
        chk("t4_lost", {63'd0, sts_locked}, 64'd0);
        send_good(17);
        chk("t4_relock", {63'd0, sts_locked}, 64'd1);

        // 5: clean stream with random gaps
        step(1'b1, tx, 1'b1);
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, tx, 1'b0);
                tx = nxt(tx);
            end else begin
                step(1'b0, {$urandom, $urandom}, 1'b0);
            end
        end
        send_good(20);
        chk("t5_locked", {63'd0, sts_locked},  64'd1);
        chk("t5_errs",   {56'd0, sts_err_cnt}, 64'd0);

        // 6a: clear with a simultaneous beat
        send_bad(64'h3);
        step(1'b1, tx, 1'b1);
        tx = nxt(tx);
        chk("t6_clr_lock", {63'd0, sts_locked},   64'd0);
        chk("t6_clr_beat", {56'd0, sts_beat_cnt}, 64'd0);
        send_good(17);
        chk("t6_relock", {63'd0, sts_locked}, 64'd1);

        // 6b: asynchronous reset mid-stream
        send_good(3);
        #2;
        do_reset();
        send_good(17);
        chk("t6_rst_relock", {63'd0, sts_locked}, 64'd1);

        // Saturation of the beat counter
        send_good(CMAX + 10);
        chk("sat_beat", {56'd0, sts_beat_cnt}, 64'(CMAX));

        // Saturation of the error counter (lock held by interleaving)
        for (int i = 0; i < CMAX + 10; i++) begin
            send_bad(64'hFFFF_FFFF_FFFF_FFFF);
            send_good(1);
        end
        chk("sat_err",  {56'd0, sts_err_cnt}, 64'(CMAX));
        chk("sat_lock", {63'd0, sts_locked},  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
